irq_ctrl: RTL and testbench

- Parametrised interrupt controller on the memory bus; successor to the fixed single-source irq vector wiring at computer top level.
- Aggregates NUM_IRQ peripheral interrupt lines (timer, uart, gpio, ...).
- Per-channel enable mask, edge or level mode, pending latch with write-1-to-clear, fixed priority encoder and vector register.
- Drives one irq line to the CPU and is selected by the address decoder like other io slots.

---
 rtl/irq_ctrl_if.sv | 29 ++
 rtl/irq_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_irq_ctrl.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/irq_ctrl_if.sv
// Bus interface for the irq_ctrl io slot: chip select, write enable,
// 3-bit register select, write data and combinational read data.
//   master : address decoder / CPU side (drives cs, wen, addr, din)
//   slave  : irq_ctrl side (drives dout)
interface irq_ctrl_if #(
  parameter int unsigned WIDTH = 32
) ();
  logic             cs;
  logic             wen;
  logic [2:0]       addr;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] dout;

  modport master (
    output cs,
    output wen,
    output addr,
    output din,
    input  dout
  );

  modport slave (
    input  cs,
    input  wen,
    input  addr,
    input  din,
    output dout
  );
endinterface

// File: rtl/irq_ctrl.sv
// Interrupt controller on the memory bus. Aggregates NUM_IRQ peripheral
// interrupt lines into a single registered irq to the CPU.
//
// Features:
//   per-channel enable mask, edge or level mode, pending latch with
//   write-1-to-clear, fixed priority encoder (lowest index wins) and
//   a vector register with acknowledge-by-index.
//
// Optional feature macro: IRQC_SWSET_EN
//   When defined, a write to addr 4 (SWSET) sets pending bits
//   (software-triggered interrupts). When undefined the write is ignored.
//
// Register map (addr):
//   0 PEND  R pending / W1C (edge channels only)
//   1 MASK  RW enable
//   2 MODE  RW 1 = edge, 0 = level
//   3 VEC   R {irq_valid, 26'b0, irq_vec} / W acknowledge by index din[4:0]
//   4 SWSET W set pending (optional), R 0
//   5 RAW   R synchronised input levels
//   6,7     R 0, W ignored
//
// Ports:
//   clk        system clock
//   reset      asynchronous active-low reset
//   bus        irq_ctrl_if slave: cs, wen, addr, din, dout (dout combinational)
//   irq_in     raw interrupt sources, any clock domain
//   irq        registered interrupt request to the CPU
//   irq_vec    registered index of the highest-priority active channel
//   irq_valid  registered flag: irq_vec is meaningful
//
// WIDTH must be >= 32 for the full VEC readback and >= NUM_IRQ.
module irq_ctrl #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned NUM_IRQ = 8
) (
  input  logic               clk,
  input  logic               reset,
  irq_ctrl_if.slave          bus,
  input  logic [NUM_IRQ-1:0] irq_in,
  output logic               irq,
  output logic [4:0]         irq_vec,
  output logic               irq_valid
);

  localparam int unsigned VEC_W = 5;

  localparam logic [2:0] A_PEND  = 3'd0;
  localparam logic [2:0] A_MASK  = 3'd1;
  localparam logic [2:0] A_MODE  = 3'd2;
  localparam logic [2:0] A_VEC   = 3'd3;
  localparam logic [2:0] A_SWSET = 3'd4;
  localparam logic [2:0] A_RAW   = 3'd5;

  // State
  logic [NUM_IRQ-1:0] s1_q, s2_q, prev_q;
  logic [NUM_IRQ-1:0] pend_q, pend_d;
  logic [NUM_IRQ-1:0] mask_q, mask_d;
  logic [NUM_IRQ-1:0] mode_q, mode_d;
  logic               irq_q, irq_d;
  logic [VEC_W-1:0]   vec_q, vec_d;
  logic               valid_q, valid_d;

  // Combinational helpers
  logic               wr_c;
  logic               wr_pend_c, wr_mask_c, wr_mode_c, wr_vec_c;
  logic [NUM_IRQ-1:0] din_n_c;
  logic [VEC_W-1:0]   ack_idx_c;
  logic [NUM_IRQ-1:0] ack_clr_c;
  logic [NUM_IRQ-1:0] clr_c;
  logic [NUM_IRQ-1:0] sw_set_c;
  logic [NUM_IRQ-1:0] edge_c;
  logic [NUM_IRQ-1:0] pending_c;
  logic [NUM_IRQ-1:0] active_c;
  logic [VEC_W-1:0]   enc_c;
  logic [WIDTH-1:0]   rdata_c;

  // Upper din bits are ignored by design.
  logic unused_din;
  assign unused_din = ^bus.din;

  // Bus write decode
  assign wr_c      = bus.cs & bus.wen;
  assign wr_pend_c = wr_c && (bus.addr == A_PEND);
  assign wr_mask_c = wr_c && (bus.addr == A_MASK);
  assign wr_mode_c = wr_c && (bus.addr == A_MODE);
  assign wr_vec_c  = wr_c && (bus.addr == A_VEC);
  assign din_n_c   = bus.din[NUM_IRQ-1:0];
  assign ack_idx_c = bus.din[VEC_W-1:0];

`ifdef IRQC_SWSET_EN
  // Software set: one-shot pending request for the written bits.
  assign sw_set_c = (wr_c && (bus.addr == A_SWSET)) ? din_n_c : '0;
`else
  assign sw_set_c = '0;
`endif

  // Rising edge of the synchronised source.
  assign edge_c = s2_q & ~prev_q;

  // Level channels show the synchronised level directly; pend_q only carries
  // a one-cycle software set for them. Edge channels show the latch.
  assign pending_c = pend_q | (s2_q & ~mode_q);
  assign active_c  = pending_c & mask_q;

  // Acknowledge by index; indices >= NUM_IRQ never match.
  always_comb begin
    ack_clr_c = '0;
    for (int unsigned i = 0; i < NUM_IRQ; i++) begin
      if (wr_vec_c && (ack_idx_c == VEC_W'(i))) ack_clr_c[i] = 1'b1;
    end
  end

  // Clears only apply to channels currently in edge mode.
  assign clr_c = ((wr_pend_c ? din_n_c : '0) | ack_clr_c) & mode_q;

  // Next-state for control registers and pending latch.
  always_comb begin
    mask_d = wr_mask_c ? din_n_c : mask_q;
    mode_d = wr_mode_c ? din_n_c : mode_q;
    // Using the new mode: a channel turning level drops its latch so it
    // follows s2 next cycle; a channel turning edge keeps its current value.
    // Set (edge or software) wins over a same-cycle clear.
    pend_d = (mode_d & ((pending_c & ~clr_c) | edge_c)) | sw_set_c;
  end

  // Fixed priority encoder, lowest index wins.
  always_comb begin
    enc_c = '0;
    for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
      if (active_c[i]) enc_c = VEC_W'(i);
    end
  end

  // Output register next-state; vector holds when nothing is active.
  always_comb begin
    irq_d   = |active_c;
    valid_d = |active_c;
    vec_d   = (|active_c) ? enc_c : vec_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q    <= '0;
      s2_q    <= '0;
      prev_q  <= '0;
      pend_q  <= '0;
      mask_q  <= '0;
      mode_q  <= '0;
      irq_q   <= 1'b0;
      vec_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      s1_q    <= irq_in;
      s2_q    <= s1_q;
      prev_q  <= s2_q;
      pend_q  <= pend_d;
      mask_q  <= mask_d;
      mode_q  <= mode_d;
      irq_q   <= irq_d;
      vec_q   <= vec_d;
      valid_q <= valid_d;
    end
  end

  // Read mux
  always_comb begin
    rdata_c = '0;
    unique case (bus.addr)
      A_PEND:  rdata_c = WIDTH'(pending_c);
      A_MASK:  rdata_c = WIDTH'(mask_q);
      A_MODE:  rdata_c = WIDTH'(mode_q);
      A_VEC:   rdata_c = WIDTH'({valid_q, 26'b0, vec_q});
      A_RAW:   rdata_c = WIDTH'(s2_q);
      default: rdata_c = '0;
    endcase
  end

  assign bus.dout  = bus.cs ? rdata_c : '0;
  assign irq       = irq_q;
  assign irq_vec   = vec_q;
  assign irq_valid = valid_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed testbench for irq_ctrl (WIDTH=32, NUM_IRQ=8).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_irq_ctrl;

  logic       clk;
  logic       reset;
  logic [7:0] irq_in;
  logic       irq;
  logic [4:0] irq_vec;
  logic       irq_valid;

  int tests;
  int errors;

  irq_ctrl_if #(.WIDTH(32)) bus ();

  irq_ctrl #(.WIDTH(32), .NUM_IRQ(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .irq_in    (irq_in),
    .irq       (irq),
    .irq_vec   (irq_vec),
    .irq_valid (irq_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    bus.cs   = 1'b1;
    bus.wen  = 1'b1;
    bus.addr = a;
    bus.din  = d;
    @(posedge clk);
    @(negedge clk);
    bus.cs   = 1'b0;
    bus.wen  = 1'b0;
    bus.din  = '0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    bus.cs   = 1'b1;
    bus.wen  = 1'b0;
    bus.addr = a;
    #1;
    d = bus.dout;
    bus.cs = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    reset  = 1'b0;
    irq_in = 8'hFF;
    tick(3);
    for (int a = 0; a < 8; a++) begin
      bus_read(3'(a), rd);
      tests++;
      if (rd !== 32'h0) begin
        errors++;
        $display("FAIL reset_read addr=%0d: got %h expected %h", a, rd, 32'h0);
      end
    end
    tests++;
    if (bus.dout !== 32'h0) begin
      errors++;
      $display("FAIL reset_dout_cs0: got %h expected %h", bus.dout, 32'h0);
    end
    tests++;
    if ({irq, irq_valid, irq_vec} !== 7'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected %b", {irq, irq_valid, irq_vec}, 7'h0);
    end
    reset = 1'b1;
    tick(4);
    bus_read(3'd0, rd);
    tests++;
    if (rd !== 32'hFF) begin
      errors++;
      $display("FAIL reset_pend_level: got %h expected %h", rd, 32'hFF);
    end
    bus_read(3'd5, rd);
    tests++;
    if (rd !== 32'hFF) begin
      errors++;
      $display("FAIL reset_raw: got %h expected %h", rd, 32'hFF);
    end
    tests++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL reset_irq_masked: got %b expected %b", irq, 1'b0);
    end
    irq_in = 8'h00;
    tick(4);
  endtask

  task automatic test_edge_latch();
    logic [31:0] rd;
    bus_write(3'd2, 32'h04);
    bus_write(3'd1, 32'h04);
    irq_in = 8'h04;
    tick(1);                      // edge k
    irq_in = 8'h00;
    tick(1);                      // k+1
    bus_read(3'd0, rd);
    tests++;
    if (rd !== 32'h0) begin
      errors++;
      $display("FAIL edge_pend_k1: got %h expected %h", rd, 32'h0);
    end
    tick(1);                      // k+2
    bus_read(3'd0, rd);
    tests++;
    if (rd !== 32'h04) begin
      errors++;
      $display("FAIL edge_pend_k2: got %h expected %h", rd, 32'h04);
    end
    tests++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL edge_irq_k2: got %b expected %b", irq, 1'b0);
    end
    tick(1);                      // k+3
    tests++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL edge_irq_k3: got %b expected %b", irq, 1'b1);
    end
    bus_read(3'd3, rd);
    tests++;
    if (rd !== 32'h80000002) begin
      errors++;
      $display("FAIL edge_vec: got %h expected %h", rd, 32'h80000002);
    end
    bus_write(3'd3, 32'h2);
    bus_read(3'd0, rd);
    tests++;
    if (rd !== 32'h0) begin
      errors++;
      $display("FAIL edge_ack_pend: got %h expected %h", rd, 32'h0);
    end
    tick(1);
    tests++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL edge_ack_irq: got %b expected %b", irq, 1'b0);
    end
  endtask

  task automatic test_priority();
    bus_write(3'd2, 32'hFF);
    bus_write(3'd1, 32'hFF);
    irq_in = 8'h22;
    tick(1);
    irq_in = 8'h00;
    tick(3);
    tests++;
    if ({irq, irq_valid, irq_vec} !== {1'b1, 1'b1, 5'd1}) begin
      errors++;
      $display("FAIL prio_both: got irq=%b valid=%b vec=%0d expected 1 1 1", irq, irq_valid, irq_vec);
    end
    bus_write(3'd0, 32'h02);
    tick(1);
    tests++;
    if ({irq, irq_valid, irq_vec} !== {1'b1, 1'b1, 5'd5}) begin
      errors++;
      $display("FAIL prio_second: got irq=%b valid=%b vec=%0d expected 1 1 5", irq, irq_valid, irq_vec);
    end
    bus_write(3'd0, 32'h20);
    tick(1);
    tests++;
    if ({irq, irq_valid, irq_vec} !== {1'b0, 1'b0, 5'd5}) begin
      errors++;
      $display("FAIL prio_none: got irq=%b valid=%b vec=%0d expected 0 0 5", irq, irq_valid, irq_vec);
    end
  endtask

  task automatic test_level();
    logic [31:0] rd;
    bus_write(3'd2, 32'h00);
    bus_write(3'd1, 32'h01);
    irq_in = 8'h01;
    tick(2);                      // k+1
    tests++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL level_irq_k1: got %b expected %b", irq, 1'b0);
    end
    tick(1);                      // k+2
    tests++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL level_irq_k2: got %b expected %b", irq, 1'b1);
    end
    bus_write(3'd0, 32'h01);
    tick(1);
    bus_read(3'd0, rd);
    tests++;
    if (rd !== 32'h01 || irq !== 1'b1) begin
      errors++;
      $display("FAIL level_w1c_ignored: got pend=%h irq=%b expected pend=%h irq=1", rd, irq, 32'h01);
    end
    irq_in = 8'h00;
    tick(2);                      // j+1
    tests++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL level_fall_j1: got %b expected %b", irq, 1'b1);
    end
    tick(1);                      // j+2
    tests++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL level_fall_j2: got %b expected %b", irq, 1'b0);
    end
  endtask

  task automatic test_collision();
    logic [31:0] rd;
    bus_write(3'd1, 32'h00);
    bus_write(3'd2, 32'h08);
    irq_in = 8'h08;
    tick(1);                      // k
    irq_in = 8'h00;
    tick(1);                      // k+1
    bus_write(3'd0, 32'h08);      // W1C lands on k+2 with the edge
    bus_read(3'd0, rd);
    tests++;
    if (rd !== 32'h08) begin
      errors++;
      $display("FAIL collision_set_wins: got %h expected %h", rd, 32'h08);
    end
    tick(2);
    tests++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL masked_irq: got %b expected %b", irq, 1'b0);
    end
    bus_write(3'd1, 32'h08);
    tests++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL unmask_same: got %b expected %b", irq, 1'b0);
    end
    tick(1);
    tests++;
    if (irq !== 1'b1 || irq_vec !== 5'd3) begin
      errors++;
      $display("FAIL unmask_next: got irq=%b vec=%0d expected irq=1 vec=3", irq, irq_vec);
    end
    bus_write(3'd3, 32'h9);
    bus_read(3'd0, rd);
    tests++;
    if (rd !== 32'h08) begin
      errors++;
      $display("FAIL ack_out_of_range: got %h expected %h", rd, 32'h08);
    end
    bus_write(3'd3, 32'h3);
    bus_read(3'd0, rd);
    tests++;
    if (rd !== 32'h0) begin
      errors++;
      $display("FAIL ack_ch3: got %h expected %h", rd, 32'h0);
    end
    tick(2);
  endtask

  task automatic test_swset();
    logic [31:0] rd;
    bus_write(3'd0, 32'hFF);
    bus_write(3'd2, 32'h80);
    bus_write(3'd1, 32'h80);
    bus_write(3'd4, 32'h80);
    bus_read(3'd0, rd);
`ifdef IRQC_SWSET_EN
    tests++;
    if (rd !== 32'h80) begin
      errors++;
      $display("FAIL swset_pend: got %h expected %h", rd, 32'h80);
    end
    tick(1);
    tests++;
    if (irq !== 1'b1 || irq_vec !== 5'd7) begin
      errors++;
      $display("FAIL swset_irq: got irq=%b vec=%0d expected irq=1 vec=7", irq, irq_vec);
    end
`else
    tests++;
    if (rd !== 32'h0) begin
      errors++;
      $display("FAIL swset_off_pend: got %h expected %h", rd, 32'h0);
    end
    tick(1);
    tests++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL swset_off_irq: got %b expected %b", irq, 1'b0);
    end
`endif
    bus_read(3'd4, rd);
    tests++;
    if (rd !== 32'h0) begin
      errors++;
      $display("FAIL swset_read: got %h expected %h", rd, 32'h0);
    end
    bus_read(3'd6, rd);
    tests++;
    if (rd !== 32'h0) begin
      errors++;
      $display("FAIL addr6_read: got %h expected %h", rd, 32'h0);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    bus_write(3'd2, 32'hFF);
    bus_write(3'd1, 32'hFF);
    irq_in = 8'h10;
    tick(5);
    tests++;
    if (irq !== 1'b1 || irq_vec !== 5'd4) begin
      errors++;
      $display("FAIL mid_pre: got irq=%b vec=%0d expected irq=1 vec=4", irq, irq_vec);
    end
    reset = 1'b0;
    #1;
    tests++;
    if ({irq, irq_valid, irq_vec} !== 7'h0) begin
      errors++;
      $display("FAIL mid_outputs: got %b expected %b", {irq, irq_valid, irq_vec}, 7'h0);
    end
    bus_read(3'd1, rd);
    tests++;
    if (rd !== 32'h0) begin
      errors++;
      $display("FAIL mid_mask: got %h expected %h", rd, 32'h0);
    end
    bus_read(3'd0, rd);
    tests++;
    if (rd !== 32'h0) begin
      errors++;
      $display("FAIL mid_pend: got %h expected %h", rd, 32'h0);
    end
    @(negedge clk);
    reset = 1'b1;
    bus_write(3'd2, 32'h10);      // edge mode before s2 rises
    tick(3);
    bus_read(3'd0, rd);
    tests++;
    if (rd !== 32'h10) begin
      errors++;
      $display("FAIL held_one_edge: got %h expected %h", rd, 32'h10);
    end
    bus_write(3'd0, 32'h10);
    tick(2);
    bus_read(3'd0, rd);
    tests++;
    if (rd !== 32'h0) begin
      errors++;
      $display("FAIL held_no_reedge: got %h expected %h", rd, 32'h0);
    end
    irq_in = 8'h00;
  endtask

  initial begin
    tests    = 0;
    errors   = 0;
    reset    = 1'b0;
    irq_in   = '0;
    bus.cs   = 1'b0;
    bus.wen  = 1'b0;
    bus.addr = '0;
    bus.din  = '0;
    @(negedge clk);
    test_reset();
    test_edge_latch();
    test_priority();
    test_level();
    test_collision();
    test_swset();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
